// File: rtl/hazard3_pmp_loader.sv
// Copies a PMP region table into the pmpaddr/pmpcfg CSRs, then optionally reads every
// region back and flags the lowest region whose CSR contents differ from the table.
module hazard3_pmp_loader #(
  parameter int PMP_REGIONS = 4,
  parameter int VERIFY      = 1,
  parameter int W_DATA      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        err_region,
  output logic              tbl_ren,
  output logic [4:0]        tbl_addr,
  input  logic [W_DATA-1:0] tbl_rdata,
  output logic [11:0]       cfg_addr,
  output logic              cfg_wen,
  output logic [W_DATA-1:0] cfg_wdata,
  input  logic [W_DATA-1:0] cfg_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CFG,
    S_CFGWR,
    S_VFY,
    S_DONE
  } state_t;

  localparam logic [11:0] PMPADDR0 = 12'h3b0;
  localparam logic [11:0] PMPCFG0  = 12'h3a0;
  localparam logic [3:0]  LAST_IDX = 4'(PMP_REGIONS - 1);

  state_t              r_state;
  logic [3:0]          r_idx;
  logic [1:0]          r_phase;
  logic [W_DATA-1:0]   r_acc;
  logic                r_err;
  logic [3:0]          r_err_region;

  state_t              w_state_nxt;
  logic [3:0]          w_idx_nxt;
  logic [1:0]          w_phase_nxt;
  logic                w_acc_load;
  logic                w_acc_clr;
  logic                w_mismatch;
  logic                w_clear_err;
  logic [7:0]          w_exp_byte;
  logic [7:0]          w_rd_lane;
  logic [4:0]          w_lane_bit;

  // The hardware drops bits 6:5 and does not support TOR, which reads back as OFF.
  function automatic logic [7:0] expectCfg(input logic [7:0] b);
    logic [7:0] m;
    m = b & 8'h9f;
    if (m[4:3] == 2'b01) m[4:3] = 2'b00;
    return m;
  endfunction

  assign w_lane_bit = {r_idx[1:0], 3'b000};
  assign w_exp_byte = expectCfg(tbl_rdata[7:0]);
  assign w_rd_lane  = cfg_rdata[w_lane_bit +: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_phase_nxt = r_phase;
    w_acc_load  = 1'b0;
    w_acc_clr   = 1'b0;
    w_mismatch  = 1'b0;
    w_clear_err = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    tbl_ren     = 1'b0;
    tbl_addr    = 5'd0;
    cfg_addr    = 12'd0;
    cfg_wen     = 1'b0;
    cfg_wdata   = '0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ADDR;
          w_idx_nxt   = 4'd0;
          w_phase_nxt = 2'd0;
          w_clear_err = 1'b1;
        end
      end

      S_ADDR: begin
        busy = 1'b1;
        if (!r_phase[0]) begin
          tbl_ren     = 1'b1;
          tbl_addr    = {r_idx, 1'b0};
          w_phase_nxt = 2'd1;
        end else begin
          cfg_wen     = 1'b1;
          cfg_addr    = PMPADDR0 + {8'd0, r_idx};
          cfg_wdata   = tbl_rdata;
          w_phase_nxt = 2'd0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_CFG;
            w_idx_nxt   = 4'd0;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end

      // Config bytes are packed four to a pmpcfg word before each write.
      S_CFG: begin
        busy = 1'b1;
        if (!r_phase[0]) begin
          tbl_ren     = 1'b1;
          tbl_addr    = {r_idx, 1'b1};
          w_phase_nxt = 2'd1;
        end else begin
          w_acc_load  = 1'b1;
          w_phase_nxt = 2'd0;
          if (r_idx[1:0] == 2'd3 || r_idx == LAST_IDX) begin
            w_state_nxt = S_CFGWR;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end
      end

      S_CFGWR: begin
        busy      = 1'b1;
        cfg_wen   = 1'b1;
        cfg_addr  = PMPCFG0 + {10'd0, r_idx[3:2]};
        cfg_wdata = r_acc;
        w_acc_clr = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_idx_nxt   = 4'd0;
          w_phase_nxt = 2'd0;
          w_state_nxt = (VERIFY != 0) ? S_VFY : S_DONE;
        end else begin
          w_idx_nxt   = r_idx + 4'd1;
          w_state_nxt = S_CFG;
        end
      end

      S_VFY: begin
        busy        = 1'b1;
        w_phase_nxt = r_phase + 2'd1;
        case (r_phase)
          2'd0: begin
            tbl_ren  = 1'b1;
            tbl_addr = {r_idx, 1'b0};
          end
          2'd1: begin
            cfg_addr   = PMPADDR0 + {8'd0, r_idx};
            w_mismatch = (cfg_rdata[29:0] != tbl_rdata[29:0]);
          end
          2'd2: begin
            tbl_ren  = 1'b1;
            tbl_addr = {r_idx, 1'b1};
          end
          default: begin
            cfg_addr   = PMPCFG0 + {10'd0, r_idx[3:2]};
            w_mismatch = (w_rd_lane != w_exp_byte);
            if (r_idx == LAST_IDX) begin
              w_state_nxt = S_DONE;
            end else begin
              w_idx_nxt = r_idx + 4'd1;
            end
          end
        endcase
      end

      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_phase <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Only the first mismatch is recorded; verification keeps running so timing never depends on data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc        <= '0;
      r_err        <= 1'b0;
      r_err_region <= 4'd0;
    end else begin
      if (w_acc_clr) begin
        r_acc <= '0;
      end else if (w_acc_load) begin
        r_acc[w_lane_bit +: 8] <= tbl_rdata[7:0];
      end
      if (w_clear_err) begin
        r_err        <= 1'b0;
        r_err_region <= 4'd0;
      end else if (w_mismatch && !r_err) begin
        r_err        <= 1'b1;
        r_err_region <= r_idx;
      end
    end
  end

  assign err        = r_err;
  assign err_region = r_err_region;

endmodule

// File: tb/tb_hazard3_pmp_loader.sv
// Scoreboard bench for hazard3_pmp_loader: two instances (N=4 with verify, N=5 without)
// driven against a table memory and a behavioural PMP CSR model with fault injection.
module tb_hazard3_pmp_loader;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      start;
  logic [1:0]      busy;
  logic [1:0]      done;
  logic [1:0]      err;
  logic [1:0]      tblRen;
  logic [1:0]      cfgWen;
  logic [1:0][3:0] errRegion;
  logic [1:0][4:0] tblAddr;
  logic [1:0][11:0] cfgAddr;
  logic [1:0][31:0] tblRdata;
  logic [1:0][31:0] cfgWdata;
  logic [1:0][31:0] cfgRdata;

  logic [31:0] tbl [2][32];
  logic [31:0] pmpAddr [2][16];
  logic [7:0]  pmpCfg [2][16];
  bit          badAddr [2][16];
  bit          badCfg [2][16];
  logic [31:0] lastCfgWr [2][4];

  wr_t expQ0[$];
  wr_t expQ1[$];
  int  busyCnt [2];
  int  doneCnt [2];
  int  checks = 0;
  int  errors = 0;

  hazard3_pmp_loader #(.PMP_REGIONS(4), .VERIFY(1), .W_DATA(32)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .err_region(errRegion[0]), .tbl_ren(tblRen[0]), .tbl_addr(tblAddr[0]),
    .tbl_rdata(tblRdata[0]), .cfg_addr(cfgAddr[0]), .cfg_wen(cfgWen[0]),
    .cfg_wdata(cfgWdata[0]), .cfg_rdata(cfgRdata[0])
  );

  hazard3_pmp_loader #(.PMP_REGIONS(5), .VERIFY(0), .W_DATA(32)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .err_region(errRegion[1]), .tbl_ren(tblRen[1]), .tbl_addr(tblAddr[1]),
    .tbl_rdata(tblRdata[1]), .cfg_addr(cfgAddr[1]), .cfg_wen(cfgWen[1]),
    .cfg_wdata(cfgWdata[1]), .cfg_rdata(cfgRdata[1])
  );

  function automatic int nReg(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  function automatic bit verOn(input int k);
    return (k == 0);
  endfunction

  function automatic int busyExp(input int k);
    int n;
    n = nReg(k);
    return (verOn(k) ? 8 : 4) * n + (n + 3) / 4;
  endfunction

  // What a real PMP keeps of a written cfg byte: bits 6:5 read zero, TOR becomes OFF.
  function automatic logic [7:0] warl(input logic [7:0] b);
    logic [7:0] m;
    m = b & 8'h9f;
    if (m[4:3] == 2'b01) m[4:3] = 2'b00;
    return m;
  endfunction

  // Table memory with one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) tblRdata[k] <= tbl[k][tblAddr[k]];
  end

  // PMP CSR storage updated by the block's writes.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (cfgWen[k]) begin
        if (cfgAddr[k][11:4] == 8'h3b) begin
          pmpAddr[k][cfgAddr[k][3:0]] <= cfgWdata[k];
        end else if (cfgAddr[k][11:4] == 8'h3a && cfgAddr[k][3:2] == 2'b00) begin
          for (int l = 0; l < 4; l++)
            pmpCfg[k][{cfgAddr[k][1:0], 2'(l)}] <= warl(cfgWdata[k][8*l +: 8]);
        end
      end
    end
  end

  // Combinational CSR readback, optionally corrupted per region.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cfgRdata[k] = '0;
      if (cfgAddr[k][11:4] == 8'h3b) begin
        cfgRdata[k] = pmpAddr[k][cfgAddr[k][3:0]] ^ {31'd0, badAddr[k][cfgAddr[k][3:0]]};
      end else if (cfgAddr[k][11:4] == 8'h3a && cfgAddr[k][3:2] == 2'b00) begin
        for (int l = 0; l < 4; l++)
          cfgRdata[k][8*l +: 8] = pmpCfg[k][{cfgAddr[k][1:0], 2'(l)}] ^
                                  {7'd0, badCfg[k][{cfgAddr[k][1:0], 2'(l)}]};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkWrite(input int k);
    wr_t e;
    bit  found;
    found = 1'b0;
    if (k == 0 && expQ0.size() > 0) begin
      e = expQ0.pop_front();
      found = 1'b1;
    end else if (k == 1 && expQ1.size() > 0) begin
      e = expQ1.pop_front();
      found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_write dut%0d got addr 0x%03h data 0x%08h expected no write",
               k, cfgAddr[k], cfgWdata[k]);
    end else begin
      checkOutput("wr_addr", 32'(cfgAddr[k]), 32'(e.addr));
      checkOutput("wr_data", cfgWdata[k], e.data);
    end
    if (cfgAddr[k][11:4] == 8'h3a) lastCfgWr[k][cfgAddr[k][1:0]] = cfgWdata[k];
  endtask

  // Monitor: consumes the scoreboard on every CSR write and tallies busy/done cycles.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (busy[k]) busyCnt[k]++;
      if (done[k]) begin
        doneCnt[k]++;
        checkOutput("done_busy_low", 32'(busy[k]), 32'd0);
      end
      if (cfgWen[k]) checkWrite(k);
    end
  end

  task automatic pushExpected(input int k);
    int   n;
    wr_t  w;
    logic [31:0] word;
    n = nReg(k);
    for (int i = 0; i < n; i++) begin
      w.addr = 12'h3b0 + 12'(i);
      w.data = tbl[k][2*i];
      if (k == 0) expQ0.push_back(w); else expQ1.push_back(w);
    end
    for (int g = 0; g * 4 < n; g++) begin
      word = 32'd0;
      for (int l = 0; l < 4; l++)
        if (4 * g + l < n) word = word | (32'(tbl[k][2*(4*g+l)+1][7:0]) << (8 * l));
      w.addr = 12'h3a0 + 12'(g);
      w.data = word;
      if (k == 0) expQ0.push_back(w); else expQ1.push_back(w);
    end
  endtask

  task automatic expectedErr(input int k, output bit e, output logic [3:0] r);
    e = 1'b0;
    r = 4'd0;
    if (verOn(k)) begin
      for (int i = 0; i < nReg(k); i++) begin
        if (!e && (badAddr[k][i] || badCfg[k][i])) begin
          e = 1'b1;
          r = 4'(i);
        end
      end
    end
  endtask

  task automatic applyStimulus(input int k);
    pushExpected(k);
    busyCnt[k] = 0;
    doneCnt[k] = 0;
    for (int g = 0; g < 4; g++) lastCfgWr[k][g] = 32'hdead_beef;
    @(posedge clk);
    #1 start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
  endtask

  task automatic waitDone(input int k, input int want);
    for (int c = 0; c < 2000 && doneCnt[k] < want; c++) @(negedge clk);
    @(posedge clk);
    #1;
    if (doneCnt[k] < want) checkOutput("done_timeout", 32'(doneCnt[k]), 32'(want));
  endtask

  task automatic checkRun(input int k, input int runs);
    bit         e;
    logic [3:0] r;
    expectedErr(k, e, r);
    checkOutput("busy_cycles", 32'(busyCnt[k]), 32'(busyExp(k) * runs));
    checkOutput("done_pulses", 32'(doneCnt[k]), 32'(runs));
    checkOutput("err", 32'(err[k]), 32'(e));
    checkOutput("err_region", 32'(errRegion[k]), 32'(r));
    checkOutput("queue_empty", (k == 0) ? 32'(expQ0.size()) : 32'(expQ1.size()), 32'd0);
  endtask

  task automatic runOnce(input int k);
    applyStimulus(k);
    waitDone(k, 1);
    checkRun(k, 1);
  endtask

  task automatic clearFaults();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        badAddr[k][i] = 1'b0;
        badCfg[k][i]  = 1'b0;
      end
  endtask

  task automatic randomTable(input int k);
    for (int w = 0; w < 32; w++) tbl[k][w] = $urandom;
  endtask

  task automatic checkResetOutputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput({tag, "_busy"}, 32'(busy[k]), 32'd0);
      checkOutput({tag, "_done"}, 32'(done[k]), 32'd0);
      checkOutput({tag, "_err"}, 32'(err[k]), 32'd0);
      checkOutput({tag, "_err_region"}, 32'(errRegion[k]), 32'd0);
      checkOutput({tag, "_tbl_ren"}, 32'(tblRen[k]), 32'd0);
      checkOutput({tag, "_tbl_addr"}, 32'(tblAddr[k]), 32'd0);
      checkOutput({tag, "_cfg_addr"}, 32'(cfgAddr[k]), 32'd0);
      checkOutput({tag, "_cfg_wen"}, 32'(cfgWen[k]), 32'd0);
      checkOutput({tag, "_cfg_wdata"}, cfgWdata[k], 32'd0);
    end
  endtask

  initial begin
    bit found;
    rst   = 1'b1;
    start = 2'b00;
    clearFaults();
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 32; w++) tbl[k][w] = 32'd0;
      for (int i = 0; i < 16; i++) begin
        pmpAddr[k][i] = 32'd0;
        pmpCfg[k][i]  = 8'd0;
      end
    end
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] directed N=4 verify load");
    for (int i = 0; i < 4; i++) tbl[0][2*i] = 32'h1000_0000 + 32'(i);
    tbl[0][1] = 32'h1f; tbl[0][3] = 32'h18; tbl[0][5] = 32'h9b; tbl[0][7] = 32'h00;
    runOnce(0);
    checkOutput("pmpcfg0_directed", lastCfgWr[0][0], 32'h009b_181f);

    $display("[TB] directed N=5 no-verify load");
    randomTable(1);
    tbl[1][9] = 32'h0000_00cc;
    runOnce(1);
    checkOutput("pmpcfg1_directed", lastCfgWr[1][1], 32'h0000_00cc);

    $display("[TB] TOR mapping and addr faults on regions 2 and 3");
    tbl[0][3] = 32'h0000_000f;
    badAddr[0][2] = 1'b1;
    badAddr[0][3] = 1'b1;
    runOnce(0);
    checkOutput("fault_err", 32'(err[0]), 32'd1);
    checkOutput("fault_err_region", 32'(errRegion[0]), 32'd2);

    $display("[TB] reset during CFG of region 1");
    clearFaults();
    applyStimulus(0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (tblRen[0] && tblAddr[0] == 5'd3) found = 1'b1;
    end
    checkOutput("reached_cfg1", 32'(found), 32'd1);
    rst = 1'b1;
    expQ0.delete();
    @(negedge clk);
    checkResetOutputs("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneCnt[0]), 32'd0);
    checkOutput("abort_idle", 32'(busy[0]), 32'd0);
    runOnce(0);

    $display("[TB] start held high for 40 cycles");
    badCfg[0][1] = 1'b1;
    runOnce(0);
    clearFaults();
    pushExpected(0);
    pushExpected(0);
    busyCnt[0] = 0;
    doneCnt[0] = 0;
    @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("err_cleared_on_start", 32'(err[0]), 32'd0);
    repeat (39) @(posedge clk);
    #1 start[0] = 1'b0;
    waitDone(0, 2);
    checkRun(0, 2);

    $display("[TB] randomized loads");
    for (int r = 0; r < 8; r++) begin
      int k;
      k = r % 2;
      clearFaults();
      randomTable(k);
      for (int i = 0; i < nReg(k); i++) begin
        badAddr[k][i] = ($urandom_range(0, 4) == 0);
        badCfg[k][i]  = ($urandom_range(0, 4) == 0);
      end
      runOnce(k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
